// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller: opcodes, FSM states
// and the fixed register-file slots that hold ALU operands.
package uart_rx_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        TX_RD    = 4'd9,
        TX_LO    = 4'd10,
        TX_HI    = 4'd11
    } state_t;

endpackage

// File: rtl/uart_rx_cmd_ctrl.sv
// Decodes command frames from the UART receiver into register-file and ALU
// strobes, and returns read data / ALU results to the transmitter one byte at a time.
module uart_rx_cmd_ctrl
    import uart_rx_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    FRAME_DROP
);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   res_hi;
    logic                    busy;
    logic                    tx_accept;

    // Bytes arriving while waiting on the RF/ALU or draining a response are discarded.
    always_comb begin
        busy = state inside {RD_WAIT, ALU_WAIT, TX_RD, TX_LO, TX_HI};
    end

    assign tx_accept = TX_VALID && TX_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_DATA     <= '0;
            TX_VALID    <= 1'b0;
            FRAME_DROP  <= 1'b0;
            res_hi      <= '0;
        end else begin
            // NOTE: strobes default low here so each branch only raises them for one cycle.
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            ALU_EN     <= 1'b0;
            FRAME_DROP <= RX_D_VLD && busy;

            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_RF_WR:  state <= WR_ADDR;
                            CMD_RF_RD:  state <= RD_ADDR;
                            CMD_ALU_OP: state <= OP_A;
                            CMD_ALU_NOP: begin
                                state       <= FUN;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default:    state <= IDLE;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (RF_RD_VLD) begin
                        TX_DATA  <= RF_RD_DATA;
                        TX_VALID <= 1'b1;
                        state    <= TX_RD;
                    end
                end
                OP_A: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= OP_B;
                    end
                end
                OP_B: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN    <= 1'b1;
                        RF_ADDR     <= ADDR_WIDTH'(OPB_ADDR);
                        RF_WR_DATA  <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state       <= FUN;
                    end
                end
                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        state   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        TX_DATA     <= ALU_OUT[DATA_WIDTH-1:0];
                        res_hi      <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        TX_VALID    <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX_LO;
                    end
                end
                TX_LO: begin
                    // TX_VALID stays high across the low/high byte boundary.
                    if (tx_accept) begin
                        TX_DATA <= res_hi;
                        state   <= TX_HI;
                    end
                end
                TX_RD, TX_HI: begin
                    if (tx_accept) begin
                        TX_VALID <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: directed frame table, hand-written
// corner sequences, then randomized frames checked against a frame-level model.
module tb_uart_rx_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_d_vld;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_vld;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic        alu_out_vld;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_drop;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_cmd_ctrl dut (
        .CLK         (clk),
        .RST         (rst),
        .RX_P_DATA   (rx_p_data),
        .RX_D_VLD    (rx_d_vld),
        .RF_WR_EN    (rf_wr_en),
        .RF_RD_EN    (rf_rd_en),
        .RF_ADDR     (rf_addr),
        .RF_WR_DATA  (rf_wr_data),
        .RF_RD_DATA  (rf_rd_data),
        .RF_RD_VLD   (rf_rd_vld),
        .ALU_EN      (alu_en),
        .ALU_FUN     (alu_fun),
        .ALU_OUT     (alu_out),
        .ALU_OUT_VLD (alu_out_vld),
        .CLK_GATE_EN (clk_gate_en),
        .TX_DATA     (tx_data),
        .TX_VALID    (tx_valid),
        .TX_READY    (tx_ready),
        .FRAME_DROP  (frame_drop)
    );

    always #5 clk = ~clk;

    // kind: 0 = RF write (b1 addr, b2 data), 1 = RF read (b1 addr, b2 read data),
    //       2 = ALU with operands (b1 A, b2 B, b3 fun), 3 = ALU without operands (b3 fun)
    typedef struct {
        int          kind;
        logic [7:0]  b1, b2, b3;
        logic [15:0] rsp;
        int          hold;
        logic [3:0]  exp_field;
        logic [7:0]  exp_lo, exp_hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] strobes();
        return {rf_wr_en, rf_rd_en, alu_en, tx_valid, frame_drop};
    endfunction

    function automatic logic [29:0] all_out();
        return {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                clk_gate_en, tx_data, tx_valid, frame_drop};
    endfunction

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        step();
        rx_d_vld  = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            tx_ready = 1'($urandom);
            step();
            tx_ready = 1'b0;
        end
    endtask

    task automatic wait_cycles(input string name, input logic cg);
        int   n;
        logic d;
        n = $urandom_range(0, 3);
        repeat (n) begin
            d         = 1'($urandom);
            rx_d_vld  = d;
            rx_p_data = 8'($urandom);
            step();
            rx_d_vld  = 1'b0;
            check(name, {strobes(), clk_gate_en}, {4'b0000, d, cg});
        end
    endtask

    task automatic tx_phase(input logic [7:0] b, input bit last, input int hold);
        logic d;
        check("tx_present", {tx_valid, tx_data}, {1'b1, b});
        repeat (hold) begin
            d         = 1'($urandom);
            rx_d_vld  = d;
            rx_p_data = 8'($urandom);
            tx_ready  = 1'b0;
            step();
            rx_d_vld  = 1'b0;
            check("tx_hold", {strobes(), tx_data}, {4'b0001, d, b});
        end
        d         = 1'($urandom);
        rx_d_vld  = d;
        rx_p_data = 8'($urandom);
        tx_ready  = 1'b1;
        step();
        tx_ready  = 1'b0;
        rx_d_vld  = 1'b0;
        if (last) check("tx_done", strobes(), {4'b0000, d});
        else      check("tx_next", strobes(), {4'b0001, d});
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input logic [3:0] exp_addr);
        send(8'hAA);
        check("wr_cmd", strobes(), 0);
        gap();
        send(addr);
        check("wr_addr", strobes(), 0);
        gap();
        send(data);
        check("wr_strobe", {strobes(), rf_addr, rf_wr_data}, {5'b10000, exp_addr, data});
        step();
        check("wr_one_cycle", strobes(), 0);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] data,
                           input logic [3:0] exp_addr, input int hold);
        logic d;
        send(8'hBB);
        check("rd_cmd", strobes(), 0);
        gap();
        send(addr);
        check("rd_strobe", {strobes(), rf_addr}, {5'b01000, exp_addr});
        wait_cycles("rd_wait", 1'b0);
        d           = 1'($urandom);
        rx_d_vld    = d;
        rx_p_data   = 8'($urandom);
        rf_rd_data  = data;
        rf_rd_vld   = 1'b1;
        step();
        rf_rd_vld   = 1'b0;
        rx_d_vld    = 1'b0;
        check("rd_capture", {strobes(), tx_data}, {4'b0001, d, data});
        tx_phase(data, 1'b1, hold);
    endtask

    task automatic do_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun, input logic [15:0] rsp, input logic [3:0] exp_fun,
                          input logic [7:0] exp_lo, input logic [7:0] exp_hi, input int hold);
        logic d;
        if (ops) begin
            send(8'hCC);
            check("alu_cmd", {strobes(), clk_gate_en}, 0);
            gap();
            send(a);
            check("opa_wr", {strobes(), rf_addr, rf_wr_data, clk_gate_en}, {5'b10000, 4'd0, a, 1'b0});
            gap();
            send(b);
            check("opb_wr", {strobes(), rf_addr, rf_wr_data, clk_gate_en}, {5'b10000, 4'd1, b, 1'b1});
        end else begin
            send(8'hDD);
            check("nop_cmd", {strobes(), clk_gate_en}, {5'b00000, 1'b1});
        end
        gap();
        send(fun);
        check("alu_strobe", {strobes(), alu_fun, clk_gate_en}, {5'b00100, exp_fun, 1'b1});
        wait_cycles("alu_wait", 1'b1);
        d           = 1'($urandom);
        rx_d_vld    = d;
        rx_p_data   = 8'($urandom);
        alu_out     = rsp;
        alu_out_vld = 1'b1;
        step();
        alu_out_vld = 1'b0;
        rx_d_vld    = 1'b0;
        check("alu_capture", {strobes(), tx_data, clk_gate_en}, {4'b0001, d, exp_lo, 1'b0});
        tx_phase(exp_lo, 1'b0, hold);
        tx_phase(exp_hi, 1'b1, hold);
    endtask

    task automatic run_vec(input vec_t v);
        case (v.kind)
            0:       do_write(v.b1, v.b2, v.exp_field);
            1:       do_read(v.b1, v.b2, v.exp_field, v.hold);
            2:       do_alu(1'b1, v.b1, v.b2, v.b3, v.rsp, v.exp_field, v.exp_lo, v.exp_hi, v.hold);
            default: do_alu(1'b0, v.b1, v.b2, v.b3, v.rsp, v.exp_field, v.exp_lo, v.exp_hi, v.hold);
        endcase
    endtask

    // Reference model: frame rules expressed as arithmetic on the received bytes.
    function automatic vec_t model_frame(input int kind, input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [15:0] rsp);
        vec_t v;
        v.kind = kind;
        v.b1   = b1;
        v.b2   = b2;
        v.b3   = b3;
        v.rsp  = rsp;
        v.hold = $urandom_range(0, 3);
        if (kind >= 2) begin
            v.exp_field = 4'(b3 % 16);
            v.exp_lo    = 8'(rsp % 256);
            v.exp_hi    = 8'(rsp / 256);
        end else begin
            v.exp_field = 4'(b1 % 16);
            v.exp_lo    = b2;
            v.exp_hi    = 8'h00;
        end
        return v;
    endfunction

    vec_t table_v[8];

    initial begin
        table_v[0] = '{0, 8'h05, 8'h3C, 8'h00, 16'h0000, 0, 4'h5, 8'h00, 8'h00};
        table_v[1] = '{1, 8'h05, 8'h3C, 8'h00, 16'h0000, 3, 4'h5, 8'h3C, 8'h00};
        table_v[2] = '{2, 8'h12, 8'h34, 8'h00, 16'h0046, 1, 4'h0, 8'h46, 8'h00};
        table_v[3] = '{3, 8'h00, 8'h00, 8'h01, 16'h1234, 0, 4'h1, 8'h34, 8'h12};
        table_v[4] = '{0, 8'hF7, 8'hA5, 8'h00, 16'h0000, 0, 4'h7, 8'h00, 8'h00};
        table_v[5] = '{1, 8'h3E, 8'hC3, 8'h00, 16'h0000, 0, 4'hE, 8'hC3, 8'h00};
        table_v[6] = '{3, 8'h00, 8'h00, 8'h3A, 16'hFFFF, 2, 4'hA, 8'hFF, 8'hFF};
        table_v[7] = '{2, 8'hFF, 8'h00, 8'h8F, 16'h8001, 1, 4'hF, 8'h01, 8'h80};

        rst         = 1'b1;
        rx_p_data   = 8'h00;
        rx_d_vld    = 1'b0;
        rf_rd_data  = 8'h00;
        rf_rd_vld   = 1'b0;
        alu_out     = 16'h0000;
        alu_out_vld = 1'b0;
        tx_ready    = 1'b0;
        step();
        step();
        check("reset_state", all_out(), 0);
        rst = 1'b0;

        send(8'h7E);
        check("unknown_byte", all_out(), 0);

        for (int i = 0; i < 8; i++) run_vec(table_v[i]);

        // Stray byte during ALU_WAIT is dropped; the frame still completes.
        send(8'hDD);
        send(8'h01);
        check("drop_fun", {strobes(), alu_fun, clk_gate_en}, {5'b00100, 4'h1, 1'b1});
        send(8'h55);
        check("drop_pulse", {strobes(), clk_gate_en}, {5'b00001, 1'b1});
        step();
        check("drop_one_cycle", {strobes(), clk_gate_en}, {5'b00000, 1'b1});
        alu_out     = 16'h0203;
        alu_out_vld = 1'b1;
        step();
        alu_out_vld = 1'b0;
        check("drop_capture", {strobes(), tx_data, clk_gate_en}, {5'b00010, 8'h03, 1'b0});
        tx_phase(8'h03, 1'b0, 0);
        tx_phase(8'h02, 1'b1, 1);

        // Reset mid-frame clears everything; a leftover operand byte is then ignored.
        send(8'hCC);
        send(8'h12);
        check("pre_rst_opa", {strobes(), rf_addr, rf_wr_data}, {5'b10000, 4'd0, 8'h12});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_frame", all_out(), 0);
        send(8'h34);
        check("post_rst_idle", all_out(), 0);
        do_write(8'h09, 8'h5A, 4'h9);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = model_frame($urandom_range(0, 3), 8'($urandom), 8'($urandom),
                            8'($urandom), 16'($urandom));
            run_vec(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
